// File: rtl/adder_arb_pkg.sv
// Shared constants for the two-requester adder arbiter: requester IDs,
// operand width and the default grant-counter width.
package adder_arb_pkg;

    localparam logic REQ0      = 1'b0;
    localparam logic REQ1      = 1'b1;
    localparam int   OPW       = 2;
    localparam int   CNT_W_DEF = 8;

endpackage : adder_arb_pkg

// File: rtl/adder_2bit.sv
// Existing 2-bit unsigned adder datapath: combinational sum and carry-out,
// no carry-in.
module adder_2bit
    import adder_arb_pkg::*;
(
    input  logic [OPW-1:0] A,
    input  logic [OPW-1:0] B,
    output logic [OPW-1:0] Sum,
    output logic           Carry
);

    logic [OPW:0] total;

    assign total = {1'b0, A} + {1'b0, B};
    assign Sum   = total[OPW-1:0];
    assign Carry = total[OPW];

endmodule : adder_2bit

// File: rtl/adder_pipe.sv
// Two-stage operand/result pipeline around one shared adder_2bit.
// S1 captures the granted operands; S2 registers sum, carry, ID and valid.
module adder_pipe
    import adder_arb_pkg::*;
(
    input  logic           Clk,
    input  logic           Rst,
    input  logic           In_vld,
    input  logic [OPW-1:0] In_a,
    input  logic [OPW-1:0] In_b,
    input  logic           In_id,
    output logic           Valid,
    output logic           Id,
    output logic [OPW-1:0] Sum_reg,
    output logic           Carry_reg
);

    logic [OPW-1:0] A_s1;
    logic [OPW-1:0] B_s1;
    logic           Id_s1;
    logic           V_s1;
    logic [OPW-1:0] sum_s1;
    logic           carry_s1;

    // S1: operand capture; data holds when nothing was granted
    always_ff @(posedge Clk) begin
        if (Rst) begin
            V_s1 <= 1'b0;
        end else begin
            V_s1 <= In_vld;
            if (In_vld) begin
                A_s1  <= In_a;
                B_s1  <= In_b;
                Id_s1 <= In_id;
            end
        end
    end

    adder_2bit u_adder (
        .A     (A_s1),
        .B     (B_s1),
        .Sum   (sum_s1),
        .Carry (carry_s1)
    );

    // S2: result register; outputs hold their last value while idle
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Valid     <= 1'b0;
            Id        <= REQ0;
            Sum_reg   <= '0;
            Carry_reg <= 1'b0;
        end else begin
            Valid <= V_s1;
            if (V_s1) begin
                Id        <= Id_s1;
                Sum_reg   <= sum_s1;
                Carry_reg <= carry_s1;
            end
        end
    end

endmodule : adder_pipe

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one pipelined 2-bit adder between two requesters.
// Define ADDER_ARB_STATS_EN to build the saturating per-requester grant counters.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Req0,
    input  logic             Req1,
    input  logic [OPW-1:0]   A0,
    input  logic [OPW-1:0]   B0,
    input  logic [OPW-1:0]   A1,
    input  logic [OPW-1:0]   B1,
    output logic             Grant0,
    output logic             Grant1,
    output logic             Valid,
    output logic             Id,
    output logic [OPW-1:0]   Sum_reg,
    output logic             Carry_reg,
    output logic [CNT_W-1:0] Cnt0,
    output logic [CNT_W-1:0] Cnt1
);

    logic           last;
    logic           any_grant;
    logic [OPW-1:0] win_a;
    logic [OPW-1:0] win_b;

    // Grants look only at requests and the round-robin pointer
    always_comb begin
        Grant0 = 1'b0;
        Grant1 = 1'b0;
        if (!Rst) begin
            unique case ({Req1, Req0})
                2'b01:   Grant0 = 1'b1;
                2'b10:   Grant1 = 1'b1;
                2'b11: begin
                    if (last == REQ1) Grant0 = 1'b1;
                    else              Grant1 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign any_grant = Grant0 | Grant1;
    assign win_a     = Grant1 ? A1 : A0;
    assign win_b     = Grant1 ? B1 : B0;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            last <= REQ1;
        end else if (any_grant) begin
            last <= Grant1 ? REQ1 : REQ0;
        end
    end

    adder_pipe u_pipe (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_vld    (any_grant),
        .In_a      (win_a),
        .In_b      (win_b),
        .In_id     (Grant1 ? REQ1 : REQ0),
        .Valid     (Valid),
        .Id        (Id),
        .Sum_reg   (Sum_reg),
        .Carry_reg (Carry_reg)
    );

`ifdef ADDER_ARB_STATS_EN
    // Counters stick at all-ones rather than wrapping
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Cnt0 <= '0;
            Cnt1 <= '0;
        end else begin
            if (Grant0 && (Cnt0 != '1)) Cnt0 <= Cnt0 + 1'b1;
            if (Grant1 && (Cnt1 != '1)) Cnt1 <= Cnt1 + 1'b1;
        end
    end
`else
    assign Cnt0 = '0;
    assign Cnt1 = '0;
`endif

endmodule : adder_arbiter
